bram_sdp_init: RTL and testbench

//  Parametrised simple-dual-port block RAM: port A read/write with byte enables, port B read-only.

---
 rtl/bram_pkg.sv | 26 ++
 rtl/bram_init_seq.sv | 59 +++++
 rtl/bram_sdp_init.sv | 148 ++++++++++++++
 tb/tb_bram_sdp_init.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants, sweep FSM state encoding and a clog2 helper for the
// initialised simple-dual-port block RAM.
package bram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    // Address width for a given depth; never below 1 so ports stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_init_seq.sv
// Reset sweep sequencer: after rst, walks every address once, requesting a
// FILL write at each, then parks in READY until the next rst.
module bram_init_seq
    import bram_pkg::*;
#(
    parameter int LEN = 256,
    parameter int AW  = clog2(LEN)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_busy,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr,
    output init_state_e   state_dbg
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

    init_state_e   state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sweep_we  = 1'b0;
        init_busy = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_we  = 1'b1;
                init_busy = 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_nxt = ST_READY;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign sweep_addr = ptr;
    assign state_dbg  = state;

endmodule

// File: rtl/bram_sdp_init.sv
// Simple-dual-port block RAM (A: read/write with byte enables, B: read-only)
// filled with FILL after reset. Define BRAM_OUT_REG_EN for a second output stage.
module bram_sdp_init
    import bram_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               LEN      = 256,
    parameter int               RDW_MODE = 0,
    parameter logic [WIDTH-1:0] FILL     = '0,
    localparam int              AW       = clog2(LEN),
    localparam int              NB       = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_busy,
    input  logic             a_en,
    input  logic             a_we,
    input  logic [NB-1:0]    a_be,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_din,
    output logic [WIDTH-1:0] a_dout,
    output logic             a_valid,
    input  logic             b_en,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b_dout,
    output logic             b_valid
);

    logic             sweep_we;
    logic [AW-1:0]    sweep_addr;
    init_state_e      seq_state;

    logic             a_acc, b_acc, a_in, b_in, a_wr, b_coll;
    logic [WIDTH-1:0] a_old, b_old, a_merged, a_rdata, b_rdata;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem [LEN];

    bram_init_seq #(.LEN(LEN), .AW(AW)) u_seq (
        .clk        (clk),
        .rst        (rst),
        .init_busy  (init_busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .state_dbg  (seq_state)
    );

    // Handshake: a request is accepted when en is high at a rising edge while the
    // sweep is finished; each accept yields exactly one valid=1 cycle, with no backpressure.
    assign a_acc  = a_en & (seq_state == ST_READY);
    assign b_acc  = b_en & (seq_state == ST_READY);
    assign a_in   = (int'(a_addr) < LEN);
    assign b_in   = (int'(b_addr) < LEN);
    assign a_wr   = a_acc & a_we & a_in;
    assign b_coll = a_wr & (b_addr == a_addr);

    assign a_old = a_in ? mem[a_addr] : '0;
    assign b_old = b_in ? mem[b_addr] : '0;

    always_comb begin
        a_merged = a_old;
        for (int i = 0; i < NB; i++) begin
            if (a_be[i]) begin
                a_merged[8*i +: 8] = a_din[8*i +: 8];
            end
        end
    end

    always_comb begin
        mem_we    = sweep_we | a_wr;
        mem_waddr = sweep_we ? sweep_addr : a_addr;
        mem_wdata = sweep_we ? FILL : a_merged;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Same-edge read-during-write returns the pre-write word or the merged word.
    always_comb begin
        a_rdata = '0;
        b_rdata = b_old;
        if (a_in) begin
            a_rdata = (a_we && RDW_MODE == RDW_WRITE_FIRST) ? a_merged : a_old;
        end
        if (b_coll && RDW_MODE == RDW_WRITE_FIRST) begin
            b_rdata = a_merged;
        end
    end

    logic [WIDTH-1:0] a_dout_q, b_dout_q;
    logic             a_valid_q, b_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dout_q  <= '0;
            b_dout_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_valid_q <= a_acc;
            b_valid_q <= b_acc;
            if (a_acc) begin
                a_dout_q <= a_rdata;
            end
            if (b_acc) begin
                b_dout_q <= b_rdata;
            end
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic [WIDTH-1:0] a_dout_q2, b_dout_q2;
    logic             a_valid_q2, b_valid_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dout_q2  <= '0;
            b_dout_q2  <= '0;
            a_valid_q2 <= 1'b0;
            b_valid_q2 <= 1'b0;
        end else begin
            a_valid_q2 <= a_valid_q;
            b_valid_q2 <= b_valid_q;
            if (a_valid_q) begin
                a_dout_q2 <= a_dout_q;
            end
            if (b_valid_q) begin
                b_dout_q2 <= b_dout_q;
            end
        end
    end

    assign a_dout  = a_dout_q2;
    assign a_valid = a_valid_q2;
    assign b_dout  = b_dout_q2;
    assign b_valid = b_valid_q2;
`else
    assign a_dout  = a_dout_q;
    assign a_valid = a_valid_q;
    assign b_dout  = b_dout_q;
    assign b_valid = b_valid_q;
`endif

endmodule

// File: tb/tb_bram_sdp_init.sv
// Directed bench: an 8-bit x 256 read-first RAM and a 32-bit x 20 write-first RAM
// exercised through sweep, byte merge, collisions, range and reset behaviour.
module tb_bram_sdp_init;

`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] FILL1 = 32'hC0FFEE00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       busy0, a0_en, a0_we, a0_valid, b0_en, b0_valid;
    logic [0:0] a0_be;
    logic [7:0] a0_addr, a0_din, a0_dout, b0_addr, b0_dout;

    logic        busy1, a1_en, a1_we, a1_valid, b1_en, b1_valid;
    logic [3:0]  a1_be;
    logic [4:0]  a1_addr, b1_addr;
    logic [31:0] a1_din, a1_dout, b1_dout;

    bram_sdp_init #(.WIDTH(8), .LEN(256), .RDW_MODE(0), .FILL(8'h00)) dut0 (
        .clk(clk), .rst(rst), .init_busy(busy0),
        .a_en(a0_en), .a_we(a0_we), .a_be(a0_be), .a_addr(a0_addr), .a_din(a0_din),
        .a_dout(a0_dout), .a_valid(a0_valid),
        .b_en(b0_en), .b_addr(b0_addr), .b_dout(b0_dout), .b_valid(b0_valid)
    );

    bram_sdp_init #(.WIDTH(32), .LEN(20), .RDW_MODE(1), .FILL(FILL1)) dut1 (
        .clk(clk), .rst(rst), .init_busy(busy1),
        .a_en(a1_en), .a_we(a1_we), .a_be(a1_be), .a_addr(a1_addr), .a_din(a1_din),
        .a_dout(a1_dout), .a_valid(a1_valid),
        .b_en(b1_en), .b_addr(b1_addr), .b_dout(b1_dout), .b_valid(b1_valid)
    );

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All driver tasks start and end on a falling edge.
    task automatic a0_op(input logic we, input logic [31:0] addr, input logic [31:0] din,
                         input logic [31:0] exp, input string tag);
        a0_en = 1'b1; a0_we = we; a0_be = 1'b1; a0_addr = addr[7:0]; a0_din = din[7:0];
        @(negedge clk);
        a0_en = 1'b0; a0_we = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk({tag, "_valid"}, 32'(a0_valid), 32'd1);
        chk(tag, 32'(a0_dout), exp);
    endtask

    task automatic b0_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        b0_en = 1'b1; b0_addr = addr[7:0];
        @(negedge clk);
        b0_en = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk({tag, "_valid"}, 32'(b0_valid), 32'd1);
        chk(tag, 32'(b0_dout), exp);
    endtask

    task automatic a1_op(input logic we, input logic [31:0] addr, input logic [31:0] din,
                         input logic [3:0] be, input logic [31:0] exp, input string tag);
        a1_en = 1'b1; a1_we = we; a1_be = be; a1_addr = addr[4:0]; a1_din = din;
        @(negedge clk);
        a1_en = 1'b0; a1_we = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk({tag, "_valid"}, 32'(a1_valid), 32'd1);
        chk(tag, a1_dout, exp);
    endtask

    task automatic b1_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        b1_en = 1'b1; b1_addr = addr[4:0];
        @(negedge clk);
        b1_en = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk({tag, "_valid"}, 32'(b1_valid), 32'd1);
        chk(tag, b1_dout, exp);
    endtask

    // Counts rising edges while each RAM reports busy; optionally pokes requests mid-sweep.
    task automatic measure(input bit inject, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        while (busy0 && c0 < 1000) begin
            @(negedge clk);
            c0++;
            if (!busy1 && c1 == 0) c1 = c0;
            if (inject) begin
                case (c0)
                    10: begin
                        a0_en = 1'b1; a0_we = 1'b1; a0_be = 1'b1; a0_addr = 8'd3; a0_din = 8'hAA;
                    end
                    11: begin
                        a0_en = 1'b0; a0_we = 1'b0;
                        chk("sweep_ign_a0_valid", 32'(a0_valid), 32'd0);
                    end
                    12: chk("sweep_ign_a0_valid2", 32'(a0_valid), 32'd0);
                    19: begin
                        a1_en = 1'b1; a1_we = 1'b1; a1_be = 4'hF; a1_addr = 5'd4; a1_din = 32'h12345678;
                    end
                    20: begin
                        a1_en = 1'b0; a1_we = 1'b0;
                        chk("final_cycle_a1_valid", 32'(a1_valid), 32'd0);
                    end
                    21: chk("final_cycle_a1_valid2", 32'(a1_valid), 32'd0);
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1, got;
        a0_en = 0; a0_we = 0; a0_be = 0; a0_addr = 0; a0_din = 0; b0_en = 0; b0_addr = 0;
        a1_en = 0; a1_we = 0; a1_be = 0; a1_addr = 0; a1_din = 0; b1_en = 0; b1_addr = 0;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_a0_valid", 32'(a0_valid), 32'd0);
        chk("rst_b0_valid", 32'(b0_valid), 32'd0);
        chk("rst_a1_dout", a1_dout, 32'd0);
        chk("rst_b1_dout", b1_dout, 32'd0);
        rst = 1'b0;

        // Sweep length, with ignored requests during the sweep
        measure(1'b1, c0, c1);
        chk("sweep_len0", c0, 256);
        chk("sweep_len1", c1, 20);

        a0_op(1'b0, 0, 0, 32'h00, "fill0_a0");
        b0_read(17, 32'h00, "fill0_b17");
        a0_op(1'b0, 255, 0, 32'h00, "fill0_a255");
        a0_op(1'b0, 3, 0, 32'h00, "sweep_ign_addr3");
        a1_op(1'b0, 0, 0, 4'h0, FILL1, "fill1_a0");
        b1_read(19, FILL1, "fill1_b19");
        b1_read(4, FILL1, "final_cycle_addr4");

        // Byte-enable merge on the write-first RAM
        a1_op(1'b1, 5, 32'h11223344, 4'hF, 32'h11223344, "wr5_full");
        a1_op(1'b1, 5, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, "wr5_merge");
        a1_op(1'b1, 5, 32'hFFFFFFFF, 4'b0000, 32'h11BB33DD, "wr5_noop");
        a1_op(1'b0, 5, 0, 4'h0, 32'h11BB33DD, "rd5");
        @(negedge clk);
        chk("hold_a1_valid", 32'(a1_valid), 32'd0);
        chk("hold_a1_dout", a1_dout, 32'h11BB33DD);

        // Out-of-range addresses on the 20-word RAM
        a1_op(1'b1, 25, 32'h55555555, 4'hF, 32'h0, "oor_wr");
        a1_op(1'b0, 25, 0, 4'h0, 32'h0, "oor_rd");
        b1_read(9, FILL1, "oor_alias9");

        // Same-address A write / B read, read-first RAM
        a0_en = 1; a0_we = 1; a0_be = 1'b1; a0_addr = 8'd9; a0_din = 8'h5A;
        b0_en = 1; b0_addr = 8'd9;
        @(negedge clk);
        a0_en = 0; a0_we = 0; b0_en = 0;
        repeat (LAT - 1) @(negedge clk);
        chk("coll0_b_valid", 32'(b0_valid), 32'd1);
        chk("coll0_b_dout", 32'(b0_dout), 32'h00);
        chk("coll0_a_dout", 32'(a0_dout), 32'h00);
        b0_read(9, 32'h5A, "coll0_after");

        // Same-address A write / B read, write-first RAM
        a1_en = 1; a1_we = 1; a1_be = 4'b0011; a1_addr = 5'd7; a1_din = 32'hDEADBEEF;
        b1_en = 1; b1_addr = 5'd7;
        @(negedge clk);
        a1_en = 0; a1_we = 0; b1_en = 0;
        repeat (LAT - 1) @(negedge clk);
        chk("coll1_b_valid", 32'(b1_valid), 32'd1);
        chk("coll1_b_dout", b1_dout, 32'hC0FFBEEF);
        chk("coll1_a_dout", a1_dout, 32'hC0FFBEEF);

        // Back-to-back B reads
        a0_op(1'b1, 1, 32'h11, 32'h00, "pre_wr1");
        a0_op(1'b1, 2, 32'h22, 32'h00, "pre_wr2");
        a0_op(1'b1, 3, 32'h33, 32'h00, "pre_wr3");
        exp_q = '{32'h11, 32'h22, 32'h33};
        got = 0;
        b0_en = 1; b0_addr = 8'd1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i < 3) b0_addr = 8'(i + 1);
            else b0_en = 1'b0;
            if (b0_valid) begin
                if (exp_q.size() > 0) begin
                    chk("b2b_data", 32'(b0_dout), exp_q.pop_front());
                    chk("b2b_cycle", i, LAT + got);
                end
                got++;
            end
        end
        chk("b2b_count", got, 3);

        // Reset in READY, then again mid-sweep
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_busy0", 32'(busy0), 32'd1);
        chk("rst2_b0_dout", 32'(b0_dout), 32'h00);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_sweep_busy0", 32'(busy0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        measure(1'b0, c0, c1);
        chk("resweep_len0", c0, 256);
        chk("resweep_len1", c1, 20);
        b0_read(9, 32'h00, "lost9");
        a0_op(1'b0, 1, 0, 32'h00, "lost1");
        b1_read(5, FILL1, "lost5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
